// File: rtl/baud_pkg.sv
// baud_pkg: shared defaults and divisor types for the fractional baud generator
package baud_pkg;
   localparam int DVSR_W_DEF = 16;
   localparam int FRAC_W_DEF = 4;
   localparam int OVS_DEF    = 16;
   typedef struct packed {
      logic [DVSR_W_DEF-1:0] int_v;
      logic [FRAC_W_DEF-1:0] frac;
   } dvsr_t;
endpackage

// File: rtl/baud_ovs_div.sv
// baud_ovs_div: oversample index counter with bit-centre and bit-boundary decodes
module baud_ovs_div import baud_pkg::*; #(
   parameter int OVS = OVS_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic sync,
   output logic mid_tick,
   output logic bit_tick
);
   localparam int OW = $clog2(OVS);
   logic [OW-1:0] ovs_q, ovs_d;
   // next index: sync restarts the phase, each tick advances modulo OVS
   always_comb begin
      ovs_d    = sync ? '0 : tick ? ((ovs_q == OW'(OVS-1)) ? '0 : ovs_q + OW'(1)) : ovs_q;
      mid_tick = tick & (ovs_q == OW'(OVS/2-1));
      bit_tick = tick & (ovs_q == OW'(OVS-1));
   end
   // index register
   always_ff @(posedge clk or posedge reset)
      if (reset) ovs_q <= '0;
      else       ovs_q <= ovs_d;
endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional-N oversample tick generator with shadowed divisor reload
module baud_gen_frac import baud_pkg::*; #(
   parameter int DVSR_W   = DVSR_W_DEF,
   parameter int FRAC_W   = FRAC_W_DEF,
   parameter int OVS      = OVS_DEF,
   parameter int DVSR_RST = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              sync,
   input  logic              load,
   input  logic [DVSR_W-1:0] dvsr_int,
   input  logic [FRAC_W-1:0] dvsr_frac,
   output logic              tick,
   output logic              mid_tick,
   output logic              bit_tick,
   output logic              pending
);
   logic [DVSR_W:0]   cnt_q, cnt_d, limit;
   logic [FRAC_W-1:0] acc_q, acc_d, act_frac_q, act_frac_d, sh_frac_q, sh_frac_d;
   logic [DVSR_W-1:0] act_int_q, act_int_d, sh_int_q, sh_int_d;
   logic [FRAC_W:0]   sum;
   logic              carry_q, carry_d, pending_q, pending_d, apply, take_in;
   // period compare, fractional accumulate and divisor handover
   always_comb begin
      limit      = {1'b0, act_int_q} + {{DVSR_W{1'b0}}, carry_q};
      tick       = en & ~sync & (cnt_q >= limit);
      sum        = {1'b0, acc_q} + {1'b0, act_frac_q};
      apply      = sync | tick;
      take_in    = load & (apply | ~en);
      cnt_d      = apply ? '0 : en ? cnt_q + (DVSR_W+1)'(1) : cnt_q;
      acc_d      = sync ? '0 : tick ? sum[FRAC_W-1:0] : acc_q;
      carry_d    = sync ? 1'b0 : tick ? sum[FRAC_W] : carry_q;
      act_int_d  = take_in ? dvsr_int : (apply & pending_q) ? sh_int_q : act_int_q;
      act_frac_d = take_in ? dvsr_frac : (apply & pending_q) ? sh_frac_q : act_frac_q;
      sh_int_d   = load ? dvsr_int : sh_int_q;
      sh_frac_d  = load ? dvsr_frac : sh_frac_q;
      pending_d  = apply ? 1'b0 : en ? (pending_q | load) : (pending_q & ~load);
      pending    = pending_q;
   end
   // state registers; reset restores the power-on divisor and drops any pending load
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         carry_q    <= 1'b0;
         pending_q  <= 1'b0;
         act_int_q  <= DVSR_W'(DVSR_RST);
         act_frac_q <= '0;
         sh_int_q   <= DVSR_W'(DVSR_RST);
         sh_frac_q  <= '0;
      end else begin
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         carry_q    <= carry_d;
         pending_q  <= pending_d;
         act_int_q  <= act_int_d;
         act_frac_q <= act_frac_d;
         sh_int_q   <= sh_int_d;
         sh_frac_q  <= sh_frac_d;
      end
   baud_ovs_div #(.OVS(OVS)) u_ovs (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .sync     (sync),
      .mid_tick (mid_tick),
      .bit_tick (bit_tick)
   );
endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: directed checks of periods, reload, enable, sync and reset
module tb_baud_gen_frac;
   logic        clk = 1'b0, reset, en, sync, load;
   logic [15:0] dvsr_int;
   logic [3:0]  dvsr_frac;
   logic        tick, mid_tick, bit_tick, pending;
   int          n_chk = 0, n_fail = 0, seen = 0, n, total;

   baud_gen_frac dut (
      .clk(clk), .reset(reset), .en(en), .sync(sync), .load(load),
      .dvsr_int(dvsr_int), .dvsr_frac(dvsr_frac),
      .tick(tick), .mid_tick(mid_tick), .bit_tick(bit_tick), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      seen += int'(tick | mid_tick | bit_tick);
      @(posedge clk); #1;
   endtask

   task automatic wait_sig(input int sel, output int cyc);
      logic h;
      cyc = -1;
      for (int i = 1; i <= 5000; i++) begin
         @(negedge clk);
         h = (sel == 0) ? tick : (sel == 1) ? mid_tick : bit_tick;
         @(posedge clk); #1;
         if (h) begin
            cyc = i;
            break;
         end
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; sync = 1'b0; load = 1'b0; dvsr_int = '0; dvsr_frac = '0;
      @(posedge clk); #1;
      repeat (3) step();
      chk("rst_ticks", seen, 0);
      chk("rst_pending", int'(pending), 0);
      reset = 1'b0;
      wait_sig(0, n); chk("rst_first_tick", n, 11);
      wait_sig(0, n); chk("rst_tick_period", n, 11);
      sync = 1'b1; step(); sync = 1'b0;
      wait_sig(1, n); chk("mid_after_sync", n, 88);
      wait_sig(2, n); chk("bit_after_mid", n, 88);
      wait_sig(2, n); chk("bit_period", n, 176);
      dvsr_int = 4; dvsr_frac = 8; sync = 1'b1; load = 1'b1; step(); sync = 1'b0; load = 1'b0;
      wait_sig(0, n); chk("frac_first", n, 5);
      total = 0;
      for (int i = 0; i < 16; i++) begin
         wait_sig(0, n);
         chk($sformatf("frac_period%0d", i), n, (i % 2) ? 6 : 5);
         total += n;
      end
      chk("frac_16_span", total, 88);
      sync = 1'b1; step(); sync = 1'b0;
      step(); step();
      dvsr_int = 2; dvsr_frac = 0; load = 1'b1; step(); load = 1'b0;
      chk("pend_set", int'(pending), 1);
      wait_sig(0, n); chk("pend_old_period", n, 2);
      chk("pend_clear", int'(pending), 0);
      wait_sig(0, n); chk("new_period_a", n, 3);
      wait_sig(0, n); chk("new_period_b", n, 3);
      step();
      en = 1'b0; seen = 0;
      repeat (7) step();
      chk("en_low_ticks", seen, 0);
      en = 1'b1;
      wait_sig(0, n); chk("en_stretch", 1 + 7 + n, 10);
      sync = 1'b1; step(); sync = 1'b0;
      en = 1'b0; dvsr_int = 1; load = 1'b1; step(); load = 1'b0;
      chk("idle_load_pend", int'(pending), 0);
      en = 1'b1;
      wait_sig(0, n); chk("idle_load_a", n, 2);
      wait_sig(0, n); chk("idle_load_b", n, 2);
      sync = 1'b1; step(); sync = 1'b0;
      repeat (5) wait_sig(0, n);
      step();
      sync = 1'b1; step(); sync = 1'b0;
      wait_sig(0, n); chk("sync_first_tick", n, 2);
      wait_sig(1, n); chk("sync_mid", n, 14);
      dvsr_int = 0; dvsr_frac = 0; sync = 1'b1; load = 1'b1; step(); sync = 1'b0; load = 1'b0;
      wait_sig(0, n); chk("zero_div_a", n, 1);
      wait_sig(0, n); chk("zero_div_b", n, 1);
      wait_sig(2, n); chk("zero_div_bit", n, 14);
      dvsr_int = 5; sync = 1'b1; load = 1'b1; step(); sync = 1'b0; load = 1'b0;
      step();
      dvsr_int = 1; load = 1'b1; step(); load = 1'b0;
      chk("pre_rst_pend", int'(pending), 1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_outs", int'({tick, mid_tick, bit_tick}), 0);
      chk("async_rst_pend", int'(pending), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      wait_sig(0, n); chk("post_rst_a", n, 11);
      wait_sig(0, n); chk("post_rst_b", n, 11);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 Parameter DVSR_W, default 16: width of integer divisor.
REQ-002 Parameter FRAC_W, default 4: width of fractional divisor.
REQ-003 Parameter OVS, default 16: oversample ticks per bit, even, >=4.
REQ-004 Parameter DVSR_RST, default 10: integer divisor after reset.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 en  in  1  count enable; low freezes all counters.
REQ-008 sync  in  1  synchronous phase restart (receiver start-bit alignment).
REQ-009 load  in  1  one-cycle strobe capturing dvsr_int/dvsr_frac.
REQ-010 dvsr_int  in  DVSR_W  integer divisor value.
REQ-011 dvsr_frac  in  FRAC_W  fractional divisor, units of 1/2^FRAC_W cycle.
REQ-012 tick  out  1  one-cycle oversample tick.
REQ-013 mid_tick  out  1  tick at oversample index OVS/2-1 (bit-centre sample).
REQ-014 bit_tick  out  1  tick at oversample index OVS-1 (bit boundary).
REQ-015 pending  out  1  high while a loaded divisor awaits application.

Function
REQ-016 Active divisor (act_int, act_frac) SHALL set tick period = act_int+1 cycles, +1 cycle when the previous tick produced a fractional carry.
REQ-017 Period counter SHALL count 0..limit, limit = act_int + carry_q; tick asserts in the cycle counter==limit and en=1; counter then wraps to 0.
REQ-018 On each tick, accumulator SHALL update acc <= acc + act_frac (FRAC_W bits); the carry-out SHALL be registered as carry_q for the next period.
REQ-019 Average period SHALL be act_int + 1 + act_frac/2^FRAC_W cycles, exact over every 2^FRAC_W ticks.
REQ-020 act_int=0, act_frac=0 SHALL give tick every enabled cycle.
REQ-021 Oversample counter SHALL increment on each tick, modulo OVS; mid_tick = tick & (ovs==OVS/2-1); bit_tick = tick & (ovs==OVS-1).
REQ-022 en=0 SHALL hold period counter, accumulator, carry_q and oversample counter; all tick outputs low.
REQ-023 load with en=0 SHALL write act_* in the next cycle; pending stays low.
REQ-024 load with en=1 SHALL capture into shadow registers, set pending, and transfer shadow to act_* in the cycle tick asserts; pending clears the same edge.
REQ-025 load coincident with tick SHALL apply the new value to the immediately following period.
REQ-026 A second load while pending SHALL overwrite the shadow; only the last value is applied.
REQ-027 sync SHALL clear period counter, accumulator, carry_q and oversample counter on the next edge, suppress tick in that cycle, and take priority over en.
REQ-028 sync with pending or load SHALL also apply the shadow/input divisor immediately and clear pending.
REQ-029 All outputs SHALL be registered-state decodes with no combinational path from inputs to tick outputs other than en and sync gating.

Reset
REQ-030 reset SHALL set counters, accumulator, carry_q, pending, shadow_frac and act_frac to 0, act_int and shadow_int to DVSR_RST.
REQ-031 During and after reset until the first enabled count, tick, mid_tick, bit_tick and pending SHALL be 0.
REQ-032 Reset asserted mid-period SHALL discard any pending load.

Structure
REQ-033 Package baud_pkg SHALL hold default DVSR_W, FRAC_W, OVS constants and a typedef for the divisor pair struct {int, frac}.
REQ-034 Oversample counter and its mid/bit decodes SHALL be a sub-module baud_ovs_div (parameter OVS, inputs clk, reset, tick, sync).
REQ-035 Widths SHALL derive from parameters; counter width DVSR_W+1 to hold act_int+carry without overflow at act_int = 2^DVSR_W-1.

Verification
REQ-036 Reset, en=1, no load -> tick every 11 cycles, bit_tick every 176 cycles, mid_tick 88 cycles after sync.
REQ-037 load int=4 frac=8 (FRAC_W=4) -> tick periods alternate 5,6; 16 ticks span exactly 88 cycles.
REQ-038 load int=2 mid-period with en=1 -> pending high until next tick; following period 3 cycles.
REQ-039 en low 7 cycles mid-period -> no ticks, phase resumes; total period stretched by exactly 7.
REQ-040 sync at ovs index 5 -> next tick at act_int+1 cycles, ovs restarts at 0, mid_tick after OVS/2 ticks.
REQ-041 int=0 frac=0 -> tick every cycle; asynchronous reset mid-stream -> outputs low within the reset cycle, pending cleared.
